cpu_phase_ctrl: RTL and testbench

- Parametrised multi-cycle phase sequencer and PC unit for the single-issue CPU.
- Replaces the free-running modulo-4 phase counter with an FSM.
- The FSM waits on req/ack handshakes to instruction and data memory, supports global stall, halt/resume and a sticky timeout fault.
- It drives the per-phase enables consumed by fetch, register file, data memory and writeback logic, and owns the program counter.

---
 rtl/cpu_phase_ctrl.sv | 130 +++++++++++++
 tb/tb_cpu_phase_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/cpu_phase_ctrl.sv
// rtl/cpu_phase_ctrl.sv - multi-cycle phase sequencer and program counter
// FETCH/DECODE/MEM/WB with memory handshakes, stall, halt/resume and sticky timeout fault.
module cpu_phase_ctrl #(
  parameter int PC_WIDTH  = 32,
  parameter int PC_STEP   = 4,
  parameter int RESET_PC  = 0,
  parameter int TIMEOUT   = 15,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 stall,
  input  logic                 imem_ack,
  input  logic                 dmem_ack,
  input  logic                 mem_op,
  input  logic                 branch_taken,
  input  logic [PC_WIDTH-1:0]  branch_target,
  input  logic                 halt_req,
  input  logic                 resume,
  output logic [PC_WIDTH-1:0]  pc,
  output logic                 fetch_en,
  output logic                 read_en,
  output logic                 mem_en,
  output logic                 wb_en,
  output logic                 imem_req,
  output logic                 dmem_req,
  output logic                 halted,
  output logic                 fault,
  output logic [PC_WIDTH-1:0]  fault_pc,
  output logic [CNT_WIDTH-1:0] instr_retired
);

  typedef enum logic [2:0] {
    S_BOOT, S_FETCH, S_DECODE, S_MEM, S_WB, S_HALT, S_FAULT
  } state_t;

  localparam logic [7:0]          TIMEOUT_C = 8'(TIMEOUT);
  localparam logic [PC_WIDTH-1:0] STEP_C    = PC_WIDTH'(PC_STEP);
  localparam logic [PC_WIDTH-1:0] RESET_C   = PC_WIDTH'(RESET_PC);

  state_t               state, state_nxt;
  logic [PC_WIDTH-1:0]  pc_nxt, fault_pc_nxt;
  logic [CNT_WIDTH-1:0] retired_nxt;
  logic [7:0]           wcnt, wcnt_nxt;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state         <= S_BOOT;
      pc            <= RESET_C;
      fault_pc      <= '0;
      instr_retired <= '0;
      wcnt          <= '0;
    end else begin
      state         <= state_nxt;
      pc            <= pc_nxt;
      fault_pc      <= fault_pc_nxt;
      instr_retired <= retired_nxt;
      wcnt          <= wcnt_nxt;
    end
  end

  // Stall freezes every register; an ack seen only while stalled is lost.
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    fault_pc_nxt = fault_pc;
    retired_nxt  = instr_retired;
    wcnt_nxt     = wcnt;
    if (!stall) begin
      case (state)
        S_BOOT: begin
          state_nxt = S_FETCH;
          wcnt_nxt  = '0;
        end
        S_FETCH: begin
          if (imem_ack) begin
            state_nxt = S_DECODE;
            wcnt_nxt  = '0;
          end else if (wcnt == TIMEOUT_C) begin
            state_nxt    = S_FAULT;
            fault_pc_nxt = pc;
          end else begin
            wcnt_nxt = wcnt + 8'd1;
          end
        end
        S_DECODE: begin
          state_nxt = S_MEM;
          wcnt_nxt  = '0;
        end
        S_MEM: begin
          if (!mem_op || dmem_ack) begin
            state_nxt = S_WB;
            wcnt_nxt  = '0;
          end else if (wcnt == TIMEOUT_C) begin
            state_nxt    = S_FAULT;
            fault_pc_nxt = pc;
          end else begin
            wcnt_nxt = wcnt + 8'd1;
          end
        end
        S_WB: begin
          pc_nxt      = branch_taken ? branch_target : pc + STEP_C;
          retired_nxt = instr_retired + 1'b1;
          state_nxt   = halt_req ? S_HALT : S_FETCH;
          wcnt_nxt    = '0;
        end
        S_HALT: begin
          if (resume) begin
            state_nxt = S_FETCH;
            wcnt_nxt  = '0;
          end
        end
        S_FAULT: state_nxt = S_FAULT;
        default: state_nxt = S_BOOT;
      endcase
    end
  end

  always_comb begin
    fetch_en = (state == S_FETCH);
    imem_req = (state == S_FETCH);
    read_en  = (state == S_DECODE);
    mem_en   = (state == S_MEM);
    dmem_req = (state == S_MEM) && mem_op;
    wb_en    = (state == S_WB);
    halted   = (state == S_HALT);
    fault    = (state == S_FAULT);
  end

endmodule

// File: tb/tb_cpu_phase_ctrl.sv
// tb/tb_cpu_phase_ctrl.sv - self-checking bench for cpu_phase_ctrl
// Instruction table applied through a scoreboard, then stall/halt, timeout and reset sequences.
module tb_cpu_phase_ctrl;

  logic        clk = 0;
  logic        nreset, stall, imem_ack, dmem_ack, mem_op, branch_taken, halt_req, resume;
  logic [7:0]  branch_target;
  logic [7:0]  pc, fault_pc;
  logic        fetch_en, read_en, mem_en, wb_en, imem_req, dmem_req, halted, fault;
  logic [15:0] instr_retired;

  int checks = 0;
  int errors = 0;

  cpu_phase_ctrl #(
    .PC_WIDTH(8), .PC_STEP(4), .RESET_PC(0), .TIMEOUT(15), .CNT_WIDTH(16)
  ) dut (
    .clk(clk), .nreset(nreset), .stall(stall), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .mem_op(mem_op), .branch_taken(branch_taken), .branch_target(branch_target),
    .halt_req(halt_req), .resume(resume), .pc(pc), .fetch_en(fetch_en), .read_en(read_en),
    .mem_en(mem_en), .wb_en(wb_en), .imem_req(imem_req), .dmem_req(dmem_req),
    .halted(halted), .fault(fault), .fault_pc(fault_pc), .instr_retired(instr_retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         imem_wait;
    bit         mop;
    int         dmem_wait;
    bit         br;
    logic [7:0] tgt;
    int         exp_cycles;
    int         exp_ic;
    int         exp_dc;
    logic [7:0] exp_pc;
    int         exp_ret;
  } vec_t;

  typedef struct {
    int         cycles;
    int         ic;
    int         dc;
    logic [7:0] pc;
    int         ret;
  } exp_t;

  vec_t vecs[10];
  exp_t sb[$];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Starts at a negedge with the DUT in FETCH; returns at the negedge after the WB edge.
  task automatic run_instr(input int idx, input vec_t v);
    exp_t e, got;
    bit   done = 0;
    int   n = 0, ic = 0, dc = 0;
    e = '{v.exp_cycles, v.exp_ic, v.exp_dc, v.exp_pc, v.exp_ret};
    sb.push_back(e);
    mem_op = v.mop; branch_taken = v.br; branch_target = v.tgt;
    halt_req = 0; stall = 0; resume = 0;
    while (!done && n < 100) begin
      n++;
      if (imem_req) ic++;
      if (dmem_req) dc++;
      imem_ack = fetch_en && (ic > v.imem_wait);
      dmem_ack = mem_en && (dc > v.dmem_wait);
      done = wb_en;
      @(negedge clk);
    end
    imem_ack = 0; dmem_ack = 0;
    check($sformatf("row%0d_wb_reached", idx), done, 1);
    got = sb.pop_front();
    check($sformatf("row%0d_cycles", idx), n, got.cycles);
    check($sformatf("row%0d_imem_req_cycles", idx), ic, got.ic);
    check($sformatf("row%0d_dmem_req_cycles", idx), dc, got.dc);
    check($sformatf("row%0d_pc", idx), pc, got.pc);
    check($sformatf("row%0d_retired", idx), instr_retired, got.ret);
  endtask

  initial begin
    vecs[0] = '{0, 0, 0, 0, 8'h00, 4, 1, 0, 8'h04, 1};
    vecs[1] = '{0, 0, 0, 0, 8'h00, 4, 1, 0, 8'h08, 2};
    vecs[2] = '{0, 0, 0, 0, 8'h00, 4, 1, 0, 8'h0C, 3};
    vecs[3] = '{3, 1, 2, 0, 8'h00, 9, 4, 3, 8'h10, 4};
    vecs[4] = '{0, 1, 0, 1, 8'hFC, 4, 1, 1, 8'hFC, 5};
    vecs[5] = '{0, 0, 0, 0, 8'h00, 4, 1, 0, 8'h00, 6};
    vecs[6] = '{0, 0, 0, 1, 8'h40, 4, 1, 0, 8'h40, 7};
    vecs[7] = '{1, 0, 0, 0, 8'h00, 5, 2, 0, 8'h44, 8};
    vecs[8] = '{0, 1, 15, 0, 8'h00, 19, 1, 16, 8'h48, 9};
    vecs[9] = '{15, 0, 0, 0, 8'h00, 19, 16, 0, 8'h4C, 10};

    nreset = 0; stall = 0; imem_ack = 0; dmem_ack = 0; mem_op = 0;
    branch_taken = 0; branch_target = 0; halt_req = 0; resume = 0;
    repeat (2) @(negedge clk);
    check("rst_pc", pc, 0);
    check("rst_retired", instr_retired, 0);
    check("rst_fault_pc", fault_pc, 0);
    check("rst_enables", {fetch_en, read_en, mem_en, wb_en, imem_req, dmem_req, halted, fault}, 0);
    nreset = 1;
    #1 check("boot_fetch_en", fetch_en, 0);
    @(negedge clk);
    check("first_fetch_en", fetch_en, 1);

    for (int i = 0; i < 10; i++) run_instr(i, vecs[i]);

    // Stall in MEM with a pending ack, then halt at WB and resume
    imem_ack = 1; mem_op = 1; dmem_ack = 0; branch_taken = 0;
    @(negedge clk);
    check("seq_decode", read_en, 1);
    imem_ack = 0;
    @(negedge clk);
    check("seq_mem", mem_en, 1);
    stall = 1; dmem_ack = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("stall%0d_mem_en", i), mem_en, 1);
      check($sformatf("stall%0d_pc", i), pc, 8'h4C);
    end
    stall = 0; dmem_ack = 0;
    @(negedge clk);
    check("stall_ack_dropped", mem_en, 1);
    dmem_ack = 1;
    @(negedge clk);
    check("seq_wb", wb_en, 1);
    dmem_ack = 0; halt_req = 1;
    @(negedge clk);
    check("halt_halted", halted, 1);
    check("halt_pc", pc, 8'h50);
    check("halt_retired", instr_retired, 11);
    halt_req = 0;
    @(negedge clk);
    check("halt_hold", halted, 1);
    stall = 1; resume = 1;
    @(negedge clk);
    check("halt_stall_over_resume", halted, 1);
    stall = 0;
    @(negedge clk);
    check("resume_fetch_en", fetch_en, 1);
    resume = 0;

    // Timeout: imem_ack never asserted
    repeat (15) @(negedge clk);
    check("timeout_15_still_fetch", fetch_en, 1);
    @(negedge clk);
    check("timeout_fault", fault, 1);
    check("timeout_fault_pc", fault_pc, 8'h50);
    check("timeout_enables", {fetch_en, read_en, mem_en, wb_en, imem_req, dmem_req, halted}, 0);
    imem_ack = 1; resume = 1;
    repeat (3) @(negedge clk);
    check("fault_sticky", fault, 1);
    imem_ack = 0; resume = 0;

    // Async reset in MEM with dmem_req high
    nreset = 0;
    @(negedge clk);
    nreset = 1;
    @(negedge clk);
    imem_ack = 1; mem_op = 1; dmem_ack = 0;
    @(negedge clk);
    imem_ack = 0;
    @(negedge clk);
    check("pre_rst_dmem_req", dmem_req, 1);
    #2 nreset = 0;
    #1;
    check("async_rst_dmem_req", dmem_req, 0);
    check("async_rst_pc", pc, 0);
    check("async_rst_retired", instr_retired, 0);
    check("async_rst_fault", fault, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
